// File: rtl/floo_look_ahead_route_decode.sv
// Input-port receiver for look-ahead routed flits.
// Each VC has its own flit FIFO. The route that the upstream router wrote into the
// head flit is decoded into a one-hot output-port request. That request is held for
// the whole wormhole packet, and one credit is returned for each flit that is dequeued.
//
// Flit layout (FlitWidth bits):
//   [RouteDirWidth-1:0]        hdr.look_ahead_routing
//   [RouteDirWidth]            hdr.last
//   [FlitWidth-1:RouteDirWidth+1] payload
//
// Per-VC FSM:
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | head of FIFO is a packet head; route decoded from its header
//   ST_LOCKED | mid-packet; route taken from locked_dir until the tail pops
module floo_look_ahead_route_decode #(
    parameter int NumVC         = 2,
    parameter int VcDepth       = 3,
    parameter int NumRoutes     = 5,
    parameter int RouteDirWidth = 3,
    parameter int FlitWidth     = 16,
    localparam int VcIdW        = (NumVC > 1) ? $clog2(NumVC) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    input  logic [VcIdW-1:0]               vc_id_i,
    input  logic [FlitWidth-1:0]           flit_i,
    output logic [NumVC-1:0]               vc_valid_o,
    output logic [NumVC*FlitWidth-1:0]     vc_flit_o,
    output logic [NumVC*NumRoutes-1:0]     vc_route_oh_o,
    input  logic [NumVC-1:0]               vc_ready_i,
    output logic [NumVC-1:0]               credit_o,
    output logic                           overflow_o,
    output logic [NumVC-1:0]               route_err_o
);

    localparam int PtrW = (VcDepth > 1) ? $clog2(VcDepth) : 1;
    localparam int CntW = $clog2(VcDepth + 1);
    localparam int LastBit = RouteDirWidth;

    localparam logic [CntW-1:0]        CntFull   = CntW'(VcDepth);
    localparam logic [PtrW-1:0]        PtrLast   = PtrW'(VcDepth - 1);
    localparam logic [RouteDirWidth:0] RoutesLim = (RouteDirWidth + 1)'(NumRoutes);
    localparam logic [VcIdW:0]         VcLim     = (VcIdW + 1)'(NumVC);
    localparam logic [NumRoutes-1:0]   OneHot0   = NumRoutes'(1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic             vc_in_range;
    logic [NumVC-1:0] pop;
    logic [NumVC-1:0] drop;
    logic [NumVC-1:0] err_set;
    logic             overflow_d;

    assign vc_in_range = {1'b0, vc_id_i} < VcLim;

    for (genvar v = 0; v < NumVC; v++) begin : g_vc
        logic [FlitWidth-1:0]     mem [VcDepth];
        logic [PtrW-1:0]          wr_ptr;
        logic [PtrW-1:0]          rd_ptr;
        logic [CntW-1:0]          cnt;
        logic [0:0]               state;
        logic [RouteDirWidth-1:0] locked_dir;

        logic [FlitWidth-1:0]     head;
        logic [RouteDirWidth-1:0] head_dir;
        logic                     head_last;
        logic                     nonempty;
        logic                     full;
        logic                     dir_ok;
        logic                     push_req;
        logic                     push_ok;

        assign head      = mem[rd_ptr];
        assign head_dir  = head[RouteDirWidth-1:0];
        assign head_last = head[LastBit];
        assign nonempty  = (cnt != '0);
        assign full      = (cnt == CntFull);
        assign dir_ok    = {1'b0, head_dir} < RoutesLim;
        assign push_req  = valid_i && vc_in_range && (vc_id_i == VcIdW'(v));

        // A full FIFO still accepts a flit if the same VC dequeues in this cycle.
        assign push_ok   = push_req && (!full || pop[v]);
        assign drop[v]   = push_req && full && !pop[v];
        assign pop[v]    = vc_valid_o[v] && vc_ready_i[v];

        // A packet head with an out-of-range direction stalls the VC and flags an error.
        assign err_set[v] = nonempty && (state == ST_IDLE) && !dir_ok;

        assign vc_valid_o[v] = nonempty && ((state == ST_LOCKED) || dir_ok);
        assign vc_flit_o[v*FlitWidth +: FlitWidth] = head;
        assign vc_route_oh_o[v*NumRoutes +: NumRoutes] =
            !nonempty             ? '0 :
            (state == ST_LOCKED)  ? (OneHot0 << locked_dir) :
            dir_ok                ? (OneHot0 << head_dir) : '0;

        // FIFO pointers, occupancy and the wormhole route lock.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                cnt        <= '0;
                state      <= ST_IDLE;
                locked_dir <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
                end
                if (pop[v]) begin
                    rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
                end
                if (push_ok && !pop[v]) begin
                    cnt <= cnt + 1'b1;
                end else if (!push_ok && pop[v]) begin
                    cnt <= cnt - 1'b1;
                end
                if (pop[v]) begin
                    if (state == ST_IDLE) begin
                        if (!head_last) begin
                            state      <= ST_LOCKED;
                            locked_dir <= head_dir;
                        end
                    end else if (head_last) begin
                        state <= ST_IDLE;
                    end
                end
            end
        end

        // Flit storage; contents are only meaningful under the occupancy count.
        always_ff @(posedge clk_i) begin
            if (push_ok) begin
                mem[wr_ptr] <= flit_i;
            end
        end
    end

    assign overflow_d = valid_i && (!vc_in_range || (|drop));

    // Registered credit return, overflow pulse and sticky route-error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_o    <= '0;
            overflow_o  <= 1'b0;
            route_err_o <= '0;
        end else begin
            credit_o    <= pop;
            overflow_o  <= overflow_d;
            route_err_o <= route_err_o | err_set;
        end
    end

endmodule
